// File: rtl/pong_timer_pkg.sv
// pong_timer_pkg
// Shared definitions for the pong timebase blocks.
//   timer_state_e : IDLE / RUN / DONE encoding for shared-timer FSMs
//   CLK_HZ        : system clock frequency in Hz
//   DIV_1MS       : clock cycles per 1 ms tick at CLK_HZ
package pong_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  localparam int unsigned CLK_HZ  = 32'd100_000_000;
  localparam int unsigned DIV_1MS = CLK_HZ / 32'd1000;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The search starts at the slot
// after `last` and wraps, so the most recent winner has the lowest priority.
// Ports:
//   req      in  N_REQ          active requests
//   last     in  $clog2(N_REQ)  index of the previous winner
//   pick     out N_REQ          one-hot winner, zero when no request
//   pick_idx out $clog2(N_REQ)  winner index, zero when no request
module rr_arbiter
  import pong_timer_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         pick,
  output logic [$clog2(N_REQ)-1:0] pick_idx
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] idx;
  logic          found;

  // Walk last+1 .. last+N_REQ (mod N_REQ) and keep the first active request.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ms_delay_arbiter.sv
// ms_delay_arbiter
// Shares one millisecond countdown timer among N_REQ requesters. A round-robin
// arbiter hands the timer to one requester at a time; the owner's delay is
// loaded at grant, counted in DIV-cycle ticks by a prescaler that restarts on
// every grant, and `done` pulses to the owner on expiry.
// Ports:
//   clk      in  1              system clock
//   rst_n    in  1              synchronous active-low reset
//   req      in  N_REQ          level requests
//   req_ms   in  N_REQ*CW       per-requester delay in ms, slice [i*CW +: CW]
//   gnt      out N_REQ          one-hot owner while the timer is held
//   owner    out $clog2(N_REQ)  index of the current or last owner
//   done     out N_REQ          one-cycle expiry pulse to the owner
//   busy     out 1              timer held (RUN or DONE)
//   tick_ms  out 1              one-cycle pulse per elapsed millisecond
module ms_delay_arbiter
  import pong_timer_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIV   = DIV_1MS,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CW-1:0]      req_ms,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     tick_ms
);

  localparam int            IW       = $clog2(N_REQ);
  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  timer_state_e   state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q,  last_d;
  logic [N_REQ-1:0] done_q,  done_d;
  logic             busy_q,  busy_d;
  logic             tick_q,  tick_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic [CW-1:0]    ms_left_q, ms_left_d;

  logic [N_REQ-1:0] pick_s;
  logic [IW-1:0]    pick_idx_s;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req      (req),
    .last     (last_q),
    .pick     (pick_s),
    .pick_idx (pick_idx_s)
  );

  // Next-state and next-output logic for the grant / count / expiry FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    done_d    = '0;
    busy_d    = busy_q;
    tick_d    = 1'b0;
    pre_d     = pre_q;
    ms_left_d = ms_left_q;
    case (state_q)
      ST_IDLE: begin
        if (req != {N_REQ{1'b0}}) begin
          state_d   = ST_RUN;
          gnt_d     = pick_s;
          owner_d   = pick_idx_s;
          last_d    = pick_idx_s;
          ms_left_d = req_ms[pick_idx_s*CW +: CW];
          pre_d     = '0;
          busy_d    = 1'b1;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!req[owner_q]) begin
          // Abandoned request: release without done, arbitration pointer kept.
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          pre_d   = '0;
        end else if (ms_left_q == {CW{1'b0}}) begin
          // Zero-length delay spends its single RUN cycle here, so done
          // lands one cycle after gnt and no tick is produced.
          state_d         = ST_DONE;
          done_d[owner_q] = 1'b1;
        end else if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (ms_left_q == CW'(1)) begin
            state_d         = ST_DONE;
            done_d[owner_q] = 1'b1;
          end else begin
            ms_left_d = ms_left_q - CW'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      ST_DONE: begin
        // A req drop in this cycle is deliberately not examined.
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        pre_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        pre_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= IW'(N_REQ - 1);
      done_q    <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      pre_q     <= '0;
      ms_left_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      pre_q     <= pre_d;
      ms_left_q <= ms_left_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign tick_ms = tick_q;

endmodule

// File: tb/tb_ms_delay_arbiter.sv
// tb_ms_delay_arbiter
// Scoreboard bench: a timeline model predicts grant / tick / done / release
// events one cycle ahead and queues them; a monitor pops and compares each
// event the DUT presents.
module tb_ms_delay_arbiter;

  localparam int N_REQ = 4;
  localparam int DIV   = 4;
  localparam int CW    = 8;
  localparam int IW    = $clog2(N_REQ);

  localparam int EV_GNT  = 0;
  localparam int EV_TICK = 1;
  localparam int EV_DONE = 2;
  localparam int EV_REL  = 3;

  typedef struct {
    int kind;
    int owner;
    int cyc;
  } ev_t;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic [N_REQ*CW-1:0] req_ms;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    owner;
  logic [N_REQ-1:0] done;
  logic             busy;
  logic             tick_ms;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  mon_en   = 1'b0;
  ev_t sb_q[$];

  // Reference model: timeline of the current ownership.
  bit               m_active;
  int               m_owner;
  int               m_last;
  int               m_gnt_cyc;
  int               m_len;
  int               m_done_cyc;
  bit [N_REQ-1:0]   m_done_flag;

  ms_delay_arbiter #(
    .N_REQ (N_REQ),
    .DIV   (DIV),
    .CW    (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_ms  (req_ms),
    .gnt     (gnt),
    .owner   (owner),
    .done    (done),
    .busy    (busy),
    .tick_ms (tick_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(int kind, int own, int at);
    ev_t e;
    e.kind  = kind;
    e.owner = own;
    e.cyc   = at;
    sb_q.push_back(e);
  endfunction

  // Given the inputs of the current cycle, predict the events of the next one.
  function automatic void model_eval();
    int c;
    int w;
    int j;
    c = cyc;
    if (!rst_n) begin
      if (m_active) push_ev(EV_REL, 0, c + 1);
      m_active = 1'b0;
      m_last   = N_REQ - 1;
      m_owner  = 0;
    end else if (m_active) begin
      if (c == m_done_cyc) begin
        push_ev(EV_REL, m_owner, c + 1);
        m_active = 1'b0;
      end else if (!req[IW'(m_owner)]) begin
        push_ev(EV_REL, m_owner, c + 1);
        m_active = 1'b0;
      end else begin
        if (m_len > 0 && ((c + 1 - m_gnt_cyc) % DIV) == 0)
          push_ev(EV_TICK, m_owner, c + 1);
        if (c + 1 == m_done_cyc) begin
          push_ev(EV_DONE, m_owner, c + 1);
          m_done_flag[IW'(m_owner)] = 1'b1;
        end
      end
    end else if (req != '0) begin
      w = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        j = (m_last + k) % N_REQ;
        if (w < 0 && req[IW'(j)]) w = j;
      end
      m_active   = 1'b1;
      m_owner    = w;
      m_last     = w;
      m_gnt_cyc  = c + 1;
      m_len      = int'(req_ms[w*CW +: CW]);
      m_done_cyc = (m_len == 0) ? c + 2 : c + 1 + m_len * DIV;
      push_ev(EV_GNT, w, c + 1);
    end
  endfunction

  function automatic void check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void check_obs(int kind, logic [N_REQ-1:0] vec);
    ev_t              e;
    logic [N_REQ-1:0] exp_vec;
    bit               exp_busy;
    checks++;
    if (sb_q.size() == 0 || sb_q[0].cyc > cyc) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d vec=%b owner=%0d", kind, cyc, vec, owner);
    end else begin
      e        = sb_q.pop_front();
      exp_vec  = (e.kind == EV_GNT || e.kind == EV_DONE) ? (N_REQ'(1) << e.owner) : '0;
      exp_busy = (e.kind != EV_REL);
      if (e.kind != kind || e.cyc != cyc || vec != exp_vec || busy != exp_busy || int'(owner) != e.owner) begin
        failures++;
        $display("FAIL event_mismatch actual: kind=%0d cyc=%0d vec=%b busy=%0d owner=%0d expected: kind=%0d cyc=%0d vec=%b busy=%0d owner=%0d",
                 kind, cyc, vec, busy, owner, e.kind, e.cyc, exp_vec, exp_busy, e.owner);
      end
    end
  endfunction

  // Monitor: sample after each active edge, turn output changes into events.
  initial begin
    logic [N_REQ-1:0] prev_gnt;
    ev_t              e;
    prev_gnt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        prev_gnt = '0;
      end else begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          e = sb_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_event kind=%0d owner=%0d expected_cycle=%0d actual_cycle=%0d", e.kind, e.owner, e.cyc, cyc);
        end
        if (gnt != '0 && gnt != prev_gnt) check_obs(EV_GNT, gnt);
        if (tick_ms) check_obs(EV_TICK, '0);
        if (done != '0) check_obs(EV_DONE, done);
        if (gnt == '0 && prev_gnt != '0) check_obs(EV_REL, gnt);
        prev_gnt = gnt;
      end
    end
  end

  task automatic cyc_step();
    model_eval();
    @(negedge clk);
  endtask

  function automatic void drop_done();
    for (int i = 0; i < N_REQ; i++) begin
      if (m_done_flag[i]) begin
        req[i]         = 1'b0;
        m_done_flag[i] = 1'b0;
      end
    end
  endfunction

  task automatic run(int n, bit auto_drop);
    for (int i = 0; i < n; i++) begin
      if (auto_drop) drop_done();
      cyc_step();
    end
  endtask

  function automatic void set_ms(int i, int v);
    req_ms[i*CW +: CW] = CW'(v);
  endfunction

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    rst_n       = 1'b0;
    req         = '0;
    req_ms      = '0;
    m_active    = 1'b0;
    m_last      = N_REQ - 1;
    m_owner     = 0;
    m_done_flag = '0;
    @(negedge clk);
    run(3, 1'b0);

    check_val("reset_gnt",   int'(gnt),     0);
    check_val("reset_done",  int'(done),    0);
    check_val("reset_busy",  int'(busy),    0);
    check_val("reset_tick",  int'(tick_ms), 0);
    check_val("reset_owner", int'(owner),   0);

    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single request, 3 ms.
    set_ms(2, 3);
    req = 4'b0100;
    run(20, 1'b1);

    // Round-robin with all requests held, 1 ms each.
    for (int i = 0; i < N_REQ; i++) set_ms(i, 1);
    req = 4'b1111;
    run(30, 1'b0);
    req = 4'b0000;
    run(10, 1'b0);
    m_done_flag = '0;

    // Zero delay.
    set_ms(1, 0);
    req = 4'b0010;
    run(8, 1'b1);

    // Abort of a 5 ms delay with requester 0 pending.
    set_ms(3, 5);
    set_ms(0, 2);
    req = 4'b1001;
    run(6, 1'b0);
    req[3] = 1'b0;
    run(16, 1'b1);

    // Reset during RUN with requester 0 held.
    set_ms(0, 3);
    req = 4'b0001;
    run(5, 1'b0);
    rst_n = 1'b0;
    run(1, 1'b0);
    rst_n = 1'b1;
    run(20, 1'b1);

    // Late req_ms change after grant.
    req = 4'b0000;
    run(3, 1'b0);
    set_ms(0, 2);
    req = 4'b0001;
    run(1, 1'b0);
    set_ms(0, 9);
    run(14, 1'b1);

    // Randomized traffic.
    req = 4'b0000;
    m_done_flag = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            set_ms(i, int'($urandom_range(0, 3)));
            req[i] = 1'b1;
          end
        end else if (m_done_flag[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          m_done_flag[i] = 1'b0;
        end else if ($urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 5) == 0) set_ms(int'($urandom_range(0, N_REQ - 1)), int'($urandom_range(0, 3)));
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc_step();
    end

    rst_n = 1'b1;
    req   = 4'b0000;
    run(40, 1'b0);

    check_val("scoreboard_empty", sb_q.size(), 0);
    check_val("final_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
